// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button conditioner.
// Holds the per-channel debounce state encoding and default timing constants.
// Imported by the channel module and the top.
package btn_cond_pkg;

  // Debounce FSM states: level is 0 in IDLE/DB_HIGH, 1 in HELD/DB_LOW.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DB_HIGH = 2'd1,
    HELD    = 2'd2,
    DB_LOW  = 2'd3
  } db_state_e;

  // 10 ms stability window at 100 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // Board has four push buttons.
  localparam int unsigned N_BTN_DEFAULT = 4;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, stability counter, debounce FSM.
// A clean edge first captured at edge k reaches the outputs at edge k+DEBOUNCE_CYCLES+2.
// No backpressure: strobes are single-cycle pulses that are not held for a consumer.
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic btn_press_o,
  output logic btn_release_o
);

  // DEBOUNCE_CYCLES must be >= 2 so the counter is at least one bit wide.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  db_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            level_q;
  logic            press_q;
  logic            release_q;

  // Two-stage synchroniser bringing the asynchronous button level onto clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM; the counter is cleared on every state entry so it never wraps,
  // and level/strobes are registered on the same edge as the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_q <= DB_HIGH;
            cnt_q   <= '0;
          end
        end
        DB_HIGH: begin
          if (!sync2_q) begin
            // Glitch shorter than the window: drop it silently.
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!sync2_q) begin
            state_q <= DB_LOW;
            cnt_q   <= '0;
          end
        end
        DB_LOW: begin
          if (sync2_q) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;

endmodule

// File: rtl/btn_cond.sv
// Push-button conditioner: N_BTN independent debounced levels plus press/release strobes.
// Latency DEBOUNCE_CYCLES+2 clk cycles from a stable raw edge to level/strobe.
// No backpressure: strobes are one-cycle pulses, simultaneous channels are not arbitrated.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_BTN           = N_BTN_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // One identical, fully independent conditioner per button.
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .btn_raw_i    (btn_raw[g]),
      .btn_level_o  (btn_level[g]),
      .btn_press_o  (btn_press[g]),
      .btn_release_o(btn_release[g])
    );
  end

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond with DEBOUNCE_CYCLES=8.
// Each table row: drive inputs, clock one edge, check outputs 1 time unit later.
// An input change first captured at row k shows on the outputs at row k+10.
module tb_btn_cond;

  localparam int unsigned N  = 4;
  localparam int unsigned DB = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int n_vec;
  int n_mis;

  btn_cond #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
  } vec_t;

  vec_t vecs[$];

  task automatic push(input int n, input logic r, input logic [3:0] raw,
                      input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
    vec_t v;
    v.r = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Raw pulse of 'len' rows on channel 0, observed for 35 rows.
  task automatic pulse_check(input int len, input int exp_np, input int exp_nr,
                             input int exp_tp, input int exp_tr);
    int np, nr, tp, tr;
    np = 0; nr = 0; tp = -1; tr = -1;
    for (int c = 0; c < 35; c++) begin
      rst     = 1'b0;
      btn_raw = (c < len) ? 4'b0001 : 4'b0000;
      @(posedge clk);
      #1;
      if (btn_press[0])   begin np++; tp = c; end
      if (btn_release[0]) begin nr++; tr = c; end
    end
    check_int($sformatf("pulse%0d press count", len), np, exp_np);
    check_int($sformatf("pulse%0d release count", len), nr, exp_nr);
    if (exp_np > 0) begin
      check_int($sformatf("pulse%0d press row", len), tp, exp_tp);
      check_int($sformatf("pulse%0d press-to-release gap", len), tr - tp, exp_tr - exp_tp);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_mis   = 0;
    rst     = 1'b1;
    btn_raw = '0;

    // Reset state.
    push(2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Clean press ch0, held 30 rows, then clean release.
    push(10, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(1,  0, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    push(19, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    push(10, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    push(1,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(5,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Bounce ch1: 1,0,1,0 in 3-row segments, then hold.
    push(3,  0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    push(3,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(3,  0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    push(3,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(10, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    push(1,  0, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    push(10, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    // Glitch on ch2 while idle: ignored.
    push(5,  0, 4'b0110, 4'b0010, 4'b0000, 4'b0000);
    push(10, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    // Press ch2, then 5-row dropout while held: no release.
    push(10, 0, 4'b0110, 4'b0010, 4'b0000, 4'b0000);
    push(1,  0, 4'b0110, 4'b0110, 4'b0100, 4'b0000);
    push(5,  0, 4'b0110, 4'b0110, 4'b0000, 4'b0000);
    push(5,  0, 4'b0010, 4'b0110, 4'b0000, 4'b0000);
    push(12, 0, 4'b0110, 4'b0110, 4'b0000, 4'b0000);
    // Press then release ch3.
    push(10, 0, 4'b1110, 4'b0110, 4'b0000, 4'b0000);
    push(1,  0, 4'b1110, 4'b1110, 4'b1000, 4'b0000);
    push(5,  0, 4'b1110, 4'b1110, 4'b0000, 4'b0000);
    push(10, 0, 4'b0110, 4'b1110, 4'b0000, 4'b0000);
    push(1,  0, 4'b0110, 4'b0110, 4'b0000, 4'b1000);
    push(5,  0, 4'b0110, 4'b0110, 4'b0000, 4'b0000);
    // Simultaneous release of ch1 and ch2.
    push(10, 0, 4'b0000, 4'b0110, 4'b0000, 4'b0000);
    push(1,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0110);
    push(5,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Reset 5 rows into a ch0 debounce; fresh press 10 rows after deassert.
    push(5,  0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(1,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(10, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(1,  0, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    push(5,  0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    push(10, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    push(1,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(5,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // All four pressed in one row.
    push(10, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    push(1,  0, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
    push(5,  0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    // Reset while held clears level; buttons held through it re-press.
    push(1,  1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    push(10, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    push(1,  0, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
    push(3,  0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    // Release all back to idle.
    push(10, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    push(1,  0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    push(3,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst     = vecs[i].r;
      btn_raw = vecs[i].raw;
      @(posedge clk);
      #1;
      n_vec++;
      if (btn_level !== vecs[i].lvl || btn_press !== vecs[i].prs || btn_release !== vecs[i].rel) begin
        n_mis++;
        $display("FAIL row %0d: level=%b press=%b release=%b, required level=%b press=%b release=%b",
                 i, btn_level, btn_press, btn_release, vecs[i].lvl, vecs[i].prs, vecs[i].rel);
      end
    end

    // 8 sampled cycles of high is one short of the window: nothing.
    pulse_check(8, 0, 0, 0, 0);
    // 9 sampled cycles: press at row 10, release DEBOUNCE_CYCLES+1 rows later.
    pulse_check(9, 1, 1, 10, 19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/btn_cond.md
Name: btn_cond

Overview:
- Input-side conditioner for the board's push buttons (swb[1:4]).
- Turns raw, bouncing, asynchronous button levels into clean synchronous signals on clk:
  - a debounced level per button;
  - one-cycle press and release strobes per button.
- Its strobes replace raw buttons as step/write events (read-registers, compute, write-back, custom-enable) in the register-file/ALU board top, so downstream logic runs entirely on clk.

Parameters:
- N_BTN, 4, number of button channels.
- DEBOUNCE_CYCLES, 1000000, clk cycles the synchronised input must stay stable before a change is accepted (10 ms at 100 MHz). Legal range is >= 2; simulation benches override it to 8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_raw  input  N_BTN  raw button levels, asynchronous to clk, 1 = pressed.
- btn_level  output  N_BTN  debounced level per channel.
- btn_press  output  N_BTN  one-cycle strobe when a channel's debounced level goes 0->1.
- btn_release  output  N_BTN  one-cycle strobe when a channel's debounced level goes 1->0.

Behaviour:
- Channels are fully independent, identical instances; no cross-channel interaction.
- Per channel, btn_raw[i] passes through a 2-FF synchroniser; its second-stage output is s.
- Counter cnt has width $clog2(DEBOUNCE_CYCLES) and never wraps: it is cleared on every state entry.
- Per-channel FSM, evaluated on each clk edge:
  - IDLE (level 0):
    - s=1: go to DB_HIGH, cnt=0.
  - DB_HIGH (level 0):
    - s=0: return to IDLE, no strobe; a glitch shorter than the window is discarded.
    - s=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD.
    - otherwise: cnt++.
  - HELD (level 1):
    - s=0: go to DB_LOW, cnt=0.
  - DB_LOW (level 1):
    - s=1: return to HELD, no strobe.
    - s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
    - otherwise: cnt++.
- Outputs are registered and update on the same edge as the state transition:
  - btn_level = 1 in HELD and DB_LOW;
  - btn_press = 1 only in the cycle after the DB_HIGH->HELD transition;
  - btn_release = 1 only in the cycle after the DB_LOW->IDLE transition.
- Latency: a clean edge on btn_raw held stable appears on btn_level/strobe exactly DEBOUNCE_CYCLES+2 cycles later. The 2 extra cycles are the synchroniser.
- Strobes are exactly one cycle wide, and btn_press/btn_release for one channel are never high together.
- A press shorter than DEBOUNCE_CYCLES+1 sampled cycles yields no press and no release.
- Minimum spacing between a press strobe and the following release strobe is DEBOUNCE_CYCLES+1 cycles.
- Reset (rst=1 at an edge): synchroniser FFs=0, state=IDLE, cnt=0, btn_level=0, btn_press=0, btn_release=0.
  - Reset wins over any in-progress transition; a debounce in progress is aborted with no strobe.
  - A button held through reset is seen as a fresh press: btn_press fires DEBOUNCE_CYCLES+2 cycles after rst deasserts.
- Simultaneous presses on several channels produce simultaneous strobes; no arbitration.

Decomposition:
- Shared package btn_cond_pkg holds:
  - the state encoding: IDLE=2'd0, DB_HIGH=2'd1, HELD=2'd2, DB_LOW=2'd3;
  - the default debounce constant.
- Sub-module btn_debounce_ch holds one channel: synchroniser, counter, FSM, registered outputs.
- btn_cond instantiates btn_debounce_ch N_BTN times in a generate loop and concatenates the outputs.

Test Plan (DEBOUNCE_CYCLES=8):
- Clean press: btn_raw[0] 0->1 held 30 cycles.
  - Required: btn_press[0]=1 for exactly 1 cycle, 10 cycles after the edge.
  - Required: btn_level[0]=1 from that cycle onward.
  - Required: other channels remain 0.
- Bounce: btn_raw[1] toggles 1,0,1,0 with 3-cycle segments, then holds 1.
  - Required: exactly one btn_press[1], 10 cycles after the final rising edge.
  - Required: no btn_release[1].
- Glitch rejection:
  - btn_raw[2]=1 for 5 cycles then 0 -> no strobes; btn_level[2] stays 0.
  - In HELD, btn_raw[2]=0 for 5 cycles then back to 1 -> no release; level stays 1.
- Release: after HELD, btn_raw[3] 1->0 held.
  - Required: btn_release[3]=1 for exactly 1 cycle, 10 cycles later.
  - Required: btn_level[3]=0 from that cycle onward.
- Reset mid-debounce: rst=1 for 1 cycle, 5 cycles after btn_raw[0] rises, button still held.
  - Required: no strobe before reset; all outputs 0 during reset.
  - Required: btn_press[0] fires 10 cycles after rst deasserts.
- Simultaneous: btn_raw=4'b1111 in one cycle, held.
  - Required: btn_press=4'b1111 in the same single cycle, 10 cycles later.
